// File: rtl/path_reader.sv
// Drains an attached LIFO into a local buffer, then replays the captured entries
// in push order over a valid/ready stream, flagging the final entry with out_last.
module path_reader #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned CW   = $clog2(DEPTH) + 1,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stk_nonempty,
    input  logic [W-1:0]  stk_data,
    output logic          stk_pop,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [CW-1:0] count
);

    typedef enum logic [2:0] {StIdle, StPop, StCapt, StEmit, StDone} state_e;

    localparam logic [CW-1:0] LastCnt = CW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  buf_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    // Buffer has no reset: out_valid is tied to state, so stale entries never escape.
    always_ff @(posedge clk) begin
        if (state_q == StCapt) begin
            buf_q[count_q[AW-1:0]] <= stk_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        stk_pop   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = stk_nonempty ? StPop : StDone;
                end
            end
            StPop: begin
                stk_pop = 1'b1;
                state_d = StCapt;
            end
            StCapt: begin
                count_d = count_q + CW'(1);
                // Replay starts at the oldest captured entry, i.e. the last one popped.
                idx_d   = count_q[AW-1:0];
                if (!stk_nonempty) begin
                    state_d = StEmit;
                end else if (count_q < LastCnt) begin
                    state_d = StPop;
                end else begin
                    state_d = StEmit;
                    ovf_d   = 1'b1;
                end
            end
            StEmit: begin
                out_valid = 1'b1;
                out_last  = (idx_q == '0);
                if (out_ready) begin
                    if (idx_q == '0) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q - AW'(1);
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign out_data = buf_q[idx_q];
    assign busy     = (state_q != StIdle);
    assign overflow = ovf_q;
    assign count    = count_q;

endmodule

// File: tb/tb_path_reader.sv
// Randomised and directed bench for path_reader: LIFO model, scoreboard of expected
// replay entries, and a decoupled output monitor.
module tb_path_reader;
    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef logic [W-1:0] q_t[$];
    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stk_nonempty;
    logic [W-1:0]  stk_data;
    logic          stk_pop;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [CW-1:0] count;

    path_reader #(.W(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stk_nonempty (stk_nonempty),
        .stk_data     (stk_data),
        .stk_pop      (stk_pop),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .count        (count)
    );

    always #5 clk = ~clk;

    logic [W-1:0] lifo[$];
    exp_t         sb[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           pops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // LIFO with registered read data: stk_data valid the cycle after a pop.
    always @(posedge clk) begin
        if (stk_pop) begin
            pops++;
            check("pop_on_nonempty_lifo", 32'(lifo.size() != 0), 32'd1);
            if (lifo.size() != 0) begin
                stk_data <= lifo[$];
                lifo.pop_back();
            end
        end
        stk_nonempty <= (lifo.size() != 0);
    end

    // Output monitor: compares every transfer against the scoreboard and checks stall holds.
    logic [W-1:0] prev_data;
    logic         prev_last;
    logic         prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", 32'(out_valid), 32'd1);
                check("stall_data_hold", 32'(out_data), 32'(prev_data));
                check("stall_last_hold", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                check("output_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
            end
            if (stk_pop) check("no_valid_during_pop", 32'(out_valid), 32'd0);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // ready_mode: 0 = held high, 1 = toggles each cycle from 0, 2 = random.
    task automatic run(input q_t vals, input int ready_mode, input bit noise);
        int n, n_cap, lat, p0;
        n     = vals.size();
        n_cap = (n > DEPTH) ? DEPTH : n;
        lifo.delete();
        foreach (vals[i]) lifo.push_back(vals[i]);
        // Replay is the n_cap most recently pushed entries, in push order.
        for (int i = n - n_cap; i < n; i++) sb.push_back({vals[i], (i == n - 1)});
        @(posedge clk);
        #1;
        p0        = pops;
        start     = 1'b1;
        out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 2000) begin
            if (noise) start = 1'($urandom);
            if (ready_mode == 1) out_ready = ~out_ready;
            else if (ready_mode == 2) out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        if (ready_mode == 0) check("latency", 32'(lat), 32'(3 * n_cap + 1));
        check("count", 32'(count), 32'(n_cap));
        check("overflow", 32'(overflow), 32'(n > DEPTH));
        check("pop_total", 32'(pops - p0), 32'(n_cap));
        check("lifo_remaining", 32'(lifo.size()), 32'(n - n_cap));
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("count_holds", 32'(count), 32'(n_cap));
        check("overflow_holds", 32'(overflow), 32'(n > DEPTH));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stk_pop"}, 32'(stk_pop), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        q_t q;
        int lim;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        q = '{8'h11, 8'h22, 8'h33};
        run(q, 0, 1'b0);
        q.delete();
        run(q, 0, 1'b0);
        q = '{8'hA0, 8'hB0};
        run(q, 1, 1'b0);
        q.delete();
        for (int i = 0; i < 70; i++) q.push_back(W'($urandom));
        run(q, 0, 1'b0);
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back(W'($urandom));
        run(q, 0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            q.delete();
            lim = $urandom_range(0, 70);
            for (int i = 0; i < lim; i++) q.push_back(W'($urandom));
            run(q, $urandom_range(0, 2), 1'($urandom));
        end

        // Reset during EMIT after one transfer, then a normal empty run.
        q = '{8'h11, 8'h22, 8'h33};
        lifo.delete();
        foreach (q[i]) lifo.push_back(q[i]);
        sb.push_back({8'h11, 1'b0});
        sb.push_back({8'h22, 1'b0});
        sb.push_back({8'h33, 1'b1});
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lim   = 0;
        while (!out_valid && lim < 100) begin
            @(posedge clk);
            #1;
            lim++;
        end
        check("emit_reached", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2;
        check("one_transfer_taken", 32'(sb.size()), 32'd2);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        run(q, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
